apb_accel_csr_gen2: RTL and testbench

Second-generation APB CSR block for the accelerator. Weight, image and model-parameter register counts are now parameters. Command pulses are replaced by held valid/ready requests to the weights/clauses and image glue. Results are buffered in a small FIFO that is popped by APB reads, and a status register plus an optional interrupt are added. The block sits between the APB fabric and class_top and its glue logic.

---
 rtl/accel_csr_pkg.sv | 72 +++++++
 rtl/apb_accel_csr_gen2_if.sv | 25 ++
 rtl/accel_csr_res_fifo.sv | 49 ++++
 rtl/apb_accel_csr_gen2.sv | 211 +++++++++++++++++++++
 tb/tb_apb_accel_csr_gen2.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_csr_pkg.sv
// accel_csr_pkg: shared constants and helpers for apb_accel_csr_gen2.
// Holds the word-offset functions of NUM_WEIGHT/NUM_IMG, the STATUS bit positions,
// the WCMD channel indices, the IRQ bit indices and the byte-strobe merge helper.
package accel_csr_pkg;

    // WCMD / o_cmd_valid channel indices
    typedef enum logic [1:0] {
        CMD_WR_WEIGHT  = 2'd0,
        CMD_RD_WEIGHT  = 2'd1,
        CMD_WR_CLAUSES = 2'd2,
        CMD_RD_CLAUSES = 2'd3
    } cmd_op_e;

    localparam int unsigned CMD_N = 4;

    // STATUS bit positions
    localparam int unsigned ST_IMG     = 4;
    localparam int unsigned ST_EMPTY   = 5;
    localparam int unsigned ST_FULL    = 6;
    localparam int unsigned ST_CNT_LSB = 8;
    localparam int unsigned ST_CNT_W   = 5;
    localparam int unsigned ST_RES_OVF = 16;
    localparam int unsigned ST_CMD_OVR = 17;

`ifdef ACCEL_CSR_IRQ_EN
    // IRQ_STAT / IRQ_EN bit indices
    localparam int unsigned IRQ_PUSH = 0;
    localparam int unsigned IRQ_OVF  = 1;
`endif

    // Word offsets; weights start at word 0
    function automatic int unsigned off_waddr(input int unsigned nw);
        return nw;
    endfunction
    function automatic int unsigned off_wcmd(input int unsigned nw);
        return nw + 1;
    endfunction
    function automatic int unsigned off_img(input int unsigned nw);
        return nw + 2;
    endfunction
    function automatic int unsigned off_img_cmd(input int unsigned nw, input int unsigned ni);
        return nw + 2 + ni;
    endfunction
    function automatic int unsigned off_result(input int unsigned nw, input int unsigned ni);
        return nw + 3 + ni;
    endfunction
    function automatic int unsigned off_status(input int unsigned nw, input int unsigned ni);
        return nw + 4 + ni;
    endfunction
    function automatic int unsigned off_mp(input int unsigned nw, input int unsigned ni);
        return nw + 5 + ni;
    endfunction
    function automatic int unsigned off_irq_en(input int unsigned nw, input int unsigned ni);
        return nw + 6 + ni;
    endfunction
    function automatic int unsigned off_irq_stat(input int unsigned nw, input int unsigned ni);
        return nw + 7 + ni;
    endfunction

    // Byte-wise write merge under PSTRB
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_accel_csr_gen2_if.sv
// apb_accel_csr_gen2_if: APB3/4 slave bus bundle.
// master drives PSEL/PADDR/PENABLE/PWRITE/PWDATA/PSTRB; slave returns PRDATA/PREADY/PSLVERR.
interface apb_accel_csr_gen2_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              PSEL;
    logic [ADDR_W-1:0] PADDR;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/accel_csr_res_fifo.sv
// accel_csr_res_fifo: synchronous FIFO for accelerator results.
// Ports: clk, rst (sync active-high), push/din, pop, head (current front entry),
// full, empty, count. Caller only asserts push when !full or when popping in the same cycle.
module accel_csr_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/apb_accel_csr_gen2.sv
// apb_accel_csr_gen2: APB CSR block between the fabric and class_top glue.
// Ports: PCLK, PRESET (sync active-high), apb (slave modport), weight data/address,
// o_cmd_valid/i_cmd_ready (4 held requests), image data with o_img_valid/i_img_ready,
// i_result_valid/i_result_data into the result FIFO, o_model_params, o_irq.
// Optional feature macro: ACCEL_CSR_IRQ_EN (adds IRQ_EN/IRQ_STAT and a live o_irq).
module apb_accel_csr_gen2
    import accel_csr_pkg::*;
#(
    parameter int unsigned NUM_WEIGHT = 8,
    parameter int unsigned NUM_IMG    = 32,
    parameter int unsigned MP_W       = 19,
    parameter int unsigned RES_W      = 32,
    parameter int unsigned RES_DEPTH  = 4,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    apb_accel_csr_gen2_if.slave       apb,
    output logic [32*NUM_WEIGHT-1:0]  o_weight_data,
    output logic [31:0]               o_weight_addr,
    output logic [CMD_N-1:0]          o_cmd_valid,
    input  logic [CMD_N-1:0]          i_cmd_ready,
    output logic [32*NUM_IMG-1:0]     o_img_data,
    output logic                      o_img_valid,
    input  logic                      i_img_ready,
    input  logic                      i_result_valid,
    input  logic [RES_W-1:0]          i_result_data,
    output logic [MP_W-1:0]           o_model_params,
    output logic                      o_irq
);
    localparam int unsigned CNT_W     = $clog2(RES_DEPTH) + 1;
    localparam int unsigned A_WADDR   = off_waddr(NUM_WEIGHT);
    localparam int unsigned A_WCMD    = off_wcmd(NUM_WEIGHT);
    localparam int unsigned A_IMG     = off_img(NUM_WEIGHT);
    localparam int unsigned A_IMG_CMD = off_img_cmd(NUM_WEIGHT, NUM_IMG);
    localparam int unsigned A_RESULT  = off_result(NUM_WEIGHT, NUM_IMG);
    localparam int unsigned A_STATUS  = off_status(NUM_WEIGHT, NUM_IMG);
    localparam int unsigned A_MP      = off_mp(NUM_WEIGHT, NUM_IMG);
`ifdef ACCEL_CSR_IRQ_EN
    localparam int unsigned A_IRQ_EN   = off_irq_en(NUM_WEIGHT, NUM_IMG);
    localparam int unsigned A_IRQ_STAT = off_irq_stat(NUM_WEIGHT, NUM_IMG);
    localparam int unsigned A_LAST     = A_IRQ_STAT;
`else
    localparam int unsigned A_LAST     = A_MP;
`endif

    logic [ADDR_W-1:0] paddr;
    logic [31:0]       addr;
    logic access, wr, rd;
    logic hit_weight, hit_waddr, hit_wcmd, hit_img, hit_img_cmd;
    logic hit_result, hit_status, hit_mp, mapped;

    // Address decode on the word index
    assign paddr       = apb.PADDR;
    assign addr        = 32'(paddr);
    assign access      = apb.PSEL & apb.PENABLE;
    assign wr          = access & apb.PWRITE;
    assign rd          = access & ~apb.PWRITE;
    assign hit_weight  = (addr < NUM_WEIGHT);
    assign hit_waddr   = (addr == A_WADDR);
    assign hit_wcmd    = (addr == A_WCMD);
    assign hit_img     = (addr >= A_IMG) && (addr < A_IMG_CMD);
    assign hit_img_cmd = (addr == A_IMG_CMD);
    assign hit_result  = (addr == A_RESULT);
    assign hit_status  = (addr == A_STATUS);
    assign hit_mp      = (addr == A_MP);
    assign mapped      = (addr <= A_LAST);

    // Held request flags: bits 3:0 are the cmd channels, bit 4 is the image channel
    logic [4:0] req_q, req_set, req_rdy;
    logic       cmd_busy, img_busy, cmd_ovr_evt;

    always_comb begin
        req_set = '0;
        if (wr && hit_wcmd && apb.PSTRB[0])    req_set[3:0] = apb.PWDATA[3:0];
        if (wr && hit_img_cmd && apb.PSTRB[0]) req_set[4]   = apb.PWDATA[0];
    end

    assign req_rdy     = {i_img_ready, i_cmd_ready};
    assign o_cmd_valid = req_q[3:0];
    assign o_img_valid = req_q[4];
    assign cmd_busy    = |req_q[3:0];
    assign img_busy    = req_q[4];
    // Re-requesting a pending cmd channel does nothing except flag the overrun
    assign cmd_ovr_evt = |(req_set[3:0] & req_q[3:0]);

    // Result FIFO
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_evt;
    logic [RES_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign fifo_pop  = rd & hit_result & ~fifo_empty;
    assign fifo_push = i_result_valid & (~fifo_full | fifo_pop);
    assign ovf_evt   = i_result_valid & fifo_full & ~fifo_pop;

    accel_csr_res_fifo #(.DEPTH(RES_DEPTH), .W(RES_W)) u_res_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (fifo_push),
        .din   (i_result_data),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    logic res_ovf_q, cmd_ovr_q;
    logic clr_ovf, clr_ovr;

    assign clr_ovf = wr & hit_status & apb.PSTRB[2] & apb.PWDATA[ST_RES_OVF];
    assign clr_ovr = wr & hit_status & apb.PSTRB[2] & apb.PWDATA[ST_CMD_OVR];

    // Register file, handshake flags and sticky status
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            o_weight_data  <= '0;
            o_weight_addr  <= '0;
            o_img_data     <= '0;
            o_model_params <= '0;
            req_q          <= '0;
            res_ovf_q      <= 1'b0;
            cmd_ovr_q      <= 1'b0;
        end else begin
            if (wr && !cmd_busy) begin
                for (int unsigned k = 0; k < NUM_WEIGHT; k++) begin
                    if (addr == k)
                        o_weight_data[32*k +: 32] <= merge_bytes(o_weight_data[32*k +: 32],
                                                                 apb.PWDATA, apb.PSTRB);
                end
                if (hit_waddr) o_weight_addr <= merge_bytes(o_weight_addr, apb.PWDATA, apb.PSTRB);
            end
            if (wr && !img_busy) begin
                for (int unsigned k = 0; k < NUM_IMG; k++) begin
                    if (addr == A_IMG + k)
                        o_img_data[32*k +: 32] <= merge_bytes(o_img_data[32*k +: 32],
                                                              apb.PWDATA, apb.PSTRB);
                end
            end
            if (wr && hit_mp)
                o_model_params <= MP_W'(merge_bytes(32'(o_model_params), apb.PWDATA, apb.PSTRB));
            req_q     <= (req_q & ~req_rdy) | (req_set & ~req_q);
            res_ovf_q <= ovf_evt | (res_ovf_q & ~clr_ovf);
            cmd_ovr_q <= cmd_ovr_evt | (cmd_ovr_q & ~clr_ovr);
        end
    end

`ifdef ACCEL_CSR_IRQ_EN
    logic [1:0] irq_en_q, irq_stat_q, irq_clr, irq_set;

    assign irq_clr           = {2{wr & (addr == A_IRQ_STAT) & apb.PSTRB[0]}} & apb.PWDATA[1:0];
    assign irq_set[IRQ_PUSH] = fifo_push;
    assign irq_set[IRQ_OVF]  = ovf_evt;

    // Set beats a same-cycle W1C
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            o_irq      <= 1'b0;
        end else begin
            if (wr && (addr == A_IRQ_EN) && apb.PSTRB[0]) irq_en_q <= apb.PWDATA[1:0];
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
            o_irq      <= |(irq_stat_q & irq_en_q);
        end
    end
`else
    assign o_irq = 1'b0;
`endif

    logic [31:0] status, rd_val;

    always_comb begin
        status                           = '0;
        status[3:0]                      = o_cmd_valid;
        status[ST_IMG]                   = o_img_valid;
        status[ST_EMPTY]                 = fifo_empty;
        status[ST_FULL]                  = fifo_full;
        status[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(fifo_count);
        status[ST_RES_OVF]               = res_ovf_q;
        status[ST_CMD_OVR]               = cmd_ovr_q;
    end

    // Read mux; unmapped and empty-RESULT reads give 0
    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_WEIGHT; k++)
            if (addr == k) rd_val = o_weight_data[32*k +: 32];
        for (int unsigned k = 0; k < NUM_IMG; k++)
            if (addr == A_IMG + k) rd_val = o_img_data[32*k +: 32];
        if (hit_waddr)                 rd_val = o_weight_addr;
        if (hit_wcmd)                  rd_val = 32'(o_cmd_valid);
        if (hit_img_cmd)               rd_val = 32'(o_img_valid);
        if (hit_result && !fifo_empty) rd_val = 32'(fifo_head);
        if (hit_status)                rd_val = status;
        if (hit_mp)                    rd_val = 32'(o_model_params);
`ifdef ACCEL_CSR_IRQ_EN
        if (addr == A_IRQ_EN)          rd_val = 32'(irq_en_q);
        if (addr == A_IRQ_STAT)        rd_val = 32'(irq_stat_q);
`endif
    end

    assign apb.PRDATA  = (apb.PSEL && !apb.PWRITE) ? rd_val : 32'h0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access & (~mapped
                                   | (wr & hit_result)
                                   | (wr & (hit_weight | hit_waddr) & cmd_busy)
                                   | (wr & hit_img & img_busy)
                                   | (rd & hit_result & fifo_empty));
endmodule

// File: tb/tb_apb_accel_csr_gen2.sv
// tb_apb_accel_csr_gen2: directed bench for apb_accel_csr_gen2 with a queue-based
// reference model updated each clock and compared on every falling edge.
module tb_apb_accel_csr_gen2;
    localparam int unsigned NW = 8, NI = 32, MPW = 19, RW = 32, RD = 4, AW = 10;
    localparam int unsigned A_WADDR = NW, A_WCMD = NW + 1, A_IMG = NW + 2;
    localparam int unsigned A_IMGCMD = NW + 2 + NI, A_RES = NW + 3 + NI, A_STAT = NW + 4 + NI;
    localparam int unsigned A_MP = NW + 5 + NI, A_IRQEN = NW + 6 + NI, A_IRQST = NW + 7 + NI;
`ifdef ACCEL_CSR_IRQ_EN
    localparam int unsigned A_TOP = A_IRQST;
`else
    localparam int unsigned A_TOP = A_MP;
`endif

    logic PCLK = 1'b0;
    logic PRESET;
    logic [32*NW-1:0] o_weight_data;
    logic [31:0]      o_weight_addr;
    logic [3:0]       o_cmd_valid, i_cmd_ready;
    logic [32*NI-1:0] o_img_data;
    logic             o_img_valid, i_img_ready, i_result_valid, o_irq;
    logic [RW-1:0]    i_result_data;
    logic [MPW-1:0]   o_model_params;

    apb_accel_csr_gen2_if #(.ADDR_W(AW)) bus ();

    apb_accel_csr_gen2 #(
        .NUM_WEIGHT(NW), .NUM_IMG(NI), .MP_W(MPW), .RES_W(RW), .RES_DEPTH(RD), .ADDR_W(AW)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus.slave),
        .o_weight_data(o_weight_data), .o_weight_addr(o_weight_addr),
        .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
        .o_img_data(o_img_data), .o_img_valid(o_img_valid), .i_img_ready(i_img_ready),
        .i_result_valid(i_result_valid), .i_result_data(i_result_data),
        .o_model_params(o_model_params), .o_irq(o_irq)
    );

    always #5 PCLK = ~PCLK;

    int unsigned n_tests = 0, n_fail = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]    m_w [NW];
    logic [31:0]    m_img [NI];
    logic [31:0]    m_waddr;
    logic [3:0]     m_cmd;
    logic           m_imgv, m_ovf, m_ovr, m_irq;
    logic [MPW-1:0] m_mp;
    logic [1:0]     m_ien, m_ist;
    logic [31:0]    m_q [$];

    function automatic logic [31:0] bmerge(input logic [31:0] cur, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int j = 0; j < 4; j++) if (s[j]) r[8*j +: 8] = d[8*j +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(NW); k++) m_w[k] = '0;
        for (int k = 0; k < int'(NI); k++) m_img[k] = '0;
        m_waddr = '0; m_cmd = '0; m_imgv = 0; m_ovf = 0; m_ovr = 0; m_irq = 0;
        m_mp = '0; m_ien = '0; m_ist = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        int unsigned a;
        logic wr, rd, pushed, ovf_ev;
        logic [3:0] cmd_old;
        logic imgv_old;
        logic [31:0] d;
        logic [3:0] s;
        a = 32'(bus.PADDR); d = bus.PWDATA; s = bus.PSTRB;
        wr = bus.PSEL && bus.PENABLE && bus.PWRITE;
        rd = bus.PSEL && bus.PENABLE && !bus.PWRITE;
        cmd_old = m_cmd; imgv_old = m_imgv; pushed = 0; ovf_ev = 0;
`ifdef ACCEL_CSR_IRQ_EN
        m_irq = |(m_ist & m_ien);
`endif
        m_cmd = cmd_old & ~i_cmd_ready;
        if (imgv_old && i_img_ready) m_imgv = 0;
        if (wr) begin
            if (a < NW) begin
                if (cmd_old == 0) m_w[a] = bmerge(m_w[a], d, s);
            end else if (a == A_WADDR) begin
                if (cmd_old == 0) m_waddr = bmerge(m_waddr, d, s);
            end else if (a == A_WCMD) begin
                if (s[0]) for (int b = 0; b < 4; b++)
                    if (d[b]) begin
                        if (cmd_old[b]) m_ovr = 1; else m_cmd[b] = 1;
                    end
            end else if (a >= A_IMG && a < A_IMGCMD) begin
                if (!imgv_old) m_img[a - A_IMG] = bmerge(m_img[a - A_IMG], d, s);
            end else if (a == A_IMGCMD) begin
                if (s[0] && d[0] && !imgv_old) m_imgv = 1;
            end else if (a == A_STAT) begin
                if (s[2] && d[16]) m_ovf = 0;
                if (s[2] && d[17]) m_ovr = 0;
            end else if (a == A_MP) begin
                m_mp = MPW'(bmerge(32'(m_mp), d, s));
            end
`ifdef ACCEL_CSR_IRQ_EN
            else if (a == A_IRQEN && s[0]) m_ien = d[1:0];
            else if (a == A_IRQST && s[0]) m_ist = m_ist & ~d[1:0];
`endif
        end
        if (rd && a == A_RES && m_q.size() > 0) void'(m_q.pop_front());
        if (i_result_valid) begin
            if (m_q.size() < RD) begin m_q.push_back(32'(i_result_data)); pushed = 1; end
            else begin m_ovf = 1; ovf_ev = 1; end
        end
        m_ist = m_ist | {ovf_ev, pushed};
    endtask

    // Expected {PSLVERR, PRDATA} for an access-phase cycle at address a
    function automatic logic [32:0] model_access(input int unsigned a, input logic w);
        logic err;
        logic [31:0] v;
        int unsigned n;
        n = m_q.size();
        err = (a > A_TOP);
        v = 0;
        if (w) begin
            if (a == A_RES) err = 1;
            if ((a < NW || a == A_WADDR) && m_cmd != 0) err = 1;
            if (a >= A_IMG && a < A_IMGCMD && m_imgv) err = 1;
            return {err, 32'h0};
        end
        if (a == A_RES && n == 0) err = 1;
        if (!err) begin
            if (a < NW) v = m_w[a];
            else if (a == A_WADDR) v = m_waddr;
            else if (a == A_WCMD) v = 32'(m_cmd);
            else if (a >= A_IMG && a < A_IMGCMD) v = m_img[a - A_IMG];
            else if (a == A_IMGCMD) v = 32'(m_imgv);
            else if (a == A_RES) v = m_q[0];
            else if (a == A_STAT)
                v = 32'(m_cmd) + (32'(m_imgv) << 4) + (32'(n == 0) << 5) + (32'(n == RD) << 6)
                    + (n << 8) + (32'(m_ovf) << 16) + (32'(m_ovr) << 17);
            else if (a == A_MP) v = 32'(m_mp);
            else if (a == A_IRQEN) v = 32'(m_ien);
            else if (a == A_IRQST) v = 32'(m_ist);
        end
        return {err, v};
    endfunction

    always @(posedge PCLK) begin
        if (PRESET) model_reset();
        else model_step();
    end

    // Output comparison against the model every cycle
    always @(negedge PCLK) begin
        if (chk_en) begin
            logic [32*NW-1:0] ew;
            logic [32*NI-1:0] ei;
            for (int k = 0; k < int'(NW); k++) ew[32*k +: 32] = m_w[k];
            for (int k = 0; k < int'(NI); k++) ei[32*k +: 32] = m_img[k];
            check("weight_data", 256'(o_weight_data), 256'(ew));
            for (int c = 0; c < int'(NI / 8); c++)
                check($sformatf("img_data_chunk%0d", c), o_img_data[256*c +: 256], ei[256*c +: 256]);
            check("weight_addr", 256'(o_weight_addr), 256'(m_waddr));
            check("cmd_valid", 256'(o_cmd_valid), 256'(m_cmd));
            check("img_valid", 256'(o_img_valid), 256'(m_imgv));
            check("model_params", 256'(o_model_params), 256'(m_mp));
            check("irq", 256'(o_irq), 256'(m_irq));
        end
    end

    // ---------------- bus tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input int unsigned a, input logic [31:0] d, input logic [3:0] s,
                             output logic err);
        logic [32:0] e;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1;
        bus.PADDR = AW'(a); bus.PWDATA = d; bus.PSTRB = s;
        tick(1);
        bus.PENABLE = 1;
        @(negedge PCLK);
        e = model_access(a, 1'b1);
        check("pslverr_wr", 256'(bus.PSLVERR), 256'(e[32]));
        check("prdata_wr", 256'(bus.PRDATA), 256'(0));
        err = bus.PSLVERR;
        tick(1);
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    task automatic apb_read(input int unsigned a, input logic push, input logic [31:0] pv,
                            output logic [31:0] data, output logic err);
        logic [32:0] e;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = AW'(a);
        tick(1);
        bus.PENABLE = 1;
        i_result_valid = push; i_result_data = RW'(pv);
        @(negedge PCLK);
        e = model_access(a, 1'b0);
        check("pslverr_rd", 256'(bus.PSLVERR), 256'(e[32]));
        check("prdata_rd", 256'(bus.PRDATA), 256'(e[31:0]));
        data = bus.PRDATA; err = bus.PSLVERR;
        tick(1);
        bus.PSEL = 0; bus.PENABLE = 0; i_result_valid = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rv;
        logic er;
        model_reset();
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0;
        bus.PWDATA = '0; bus.PSTRB = '0;
        i_cmd_ready = '0; i_img_ready = 0; i_result_valid = 0; i_result_data = '0;
        PRESET = 1;
        tick(3);
        PRESET = 0;
        chk_en = 1;

        apb_read(A_STAT, 0, 0, rv, er);
        check("reset_status", 256'(rv), 256'(32'h0000_0020));

        apb_write(3, 32'hDEAD_BEEF, 4'b0101, er);
        check("weight3_strobe", 256'(o_weight_data[127:96]), 256'(32'h00AD_00EF));
        apb_read(3, 0, 0, rv, er);
        check("weight3_readback", 256'(rv), 256'(32'h00AD_00EF));
        apb_read(200, 0, 0, rv, er);
        check("unmapped_data", 256'(rv), 256'(0));
        check("unmapped_err", 256'(er), 256'(1));

        apb_write(A_WCMD, 32'h5, 4'hF, er);
        check("wcmd_valid", 256'(o_cmd_valid), 256'(4'b0101));
        apb_read(A_WCMD, 0, 0, rv, er);
        check("wcmd_read", 256'(rv), 256'(32'h5));
        apb_write(0, 32'h1234_5678, 4'hF, er);
        check("weight_protect_err", 256'(er), 256'(1));
        check("weight_protect_val", 256'(o_weight_data[31:0]), 256'(0));
        i_cmd_ready = 4'b0001;
        tick(1);
        i_cmd_ready = 4'b0000;
        check("cmd0_handshake", 256'(o_cmd_valid), 256'(4'b0100));

        apb_write(A_WCMD, 32'h1, 4'hF, er);
        apb_write(A_WCMD, 32'h1, 4'hF, er);
        check("overrun_single_req", 256'(o_cmd_valid), 256'(4'b0101));
        apb_read(A_STAT, 0, 0, rv, er);
        check("status_overrun", 256'(rv), 256'(32'h0002_0025));
        apb_write(A_STAT, 32'h0002_0000, 4'hF, er);
        apb_read(A_STAT, 0, 0, rv, er);
        check("status_overrun_w1c", 256'(rv), 256'(32'h0000_0025));
        i_cmd_ready = 4'hF;
        tick(1);
        i_cmd_ready = 4'h0;

        for (int v = 1; v <= 5; v++) begin
            i_result_valid = 1; i_result_data = RW'(v);
            tick(1);
        end
        i_result_valid = 0;
        apb_read(A_STAT, 0, 0, rv, er);
        check("status_full_ovf", 256'(rv), 256'(32'h0001_0440));
        for (int v = 1; v <= 4; v++) begin
            apb_read(A_RES, 0, 0, rv, er);
            check($sformatf("result_pop%0d", v), 256'(rv), 256'(v));
        end
        apb_read(A_RES, 0, 0, rv, er);
        check("result_empty_data", 256'(rv), 256'(0));
        check("result_empty_err", 256'(er), 256'(1));
        apb_write(A_STAT, 32'h0001_0000, 4'hF, er);

        for (int v = 5; v <= 8; v++) begin
            i_result_valid = 1; i_result_data = RW'(v);
            tick(1);
        end
        i_result_valid = 0;
        apb_read(A_RES, 1, 32'd9, rv, er);
        check("push_pop_full_head", 256'(rv), 256'(5));
        apb_read(A_STAT, 0, 0, rv, er);
        check("push_pop_full_status", 256'(rv), 256'(32'h0000_0440));
        for (int v = 6; v <= 9; v++) begin
            apb_read(A_RES, 0, 0, rv, er);
            check($sformatf("result_after_pp%0d", v), 256'(rv), 256'(v));
        end

        apb_write(A_MP, 32'hFFFF_FFFF, 4'hF, er);
        apb_read(A_MP, 0, 0, rv, er);
        check("mp_width", 256'(rv), 256'(32'h0007_FFFF));
        apb_write(A_WADDR, 32'h0000_00A5, 4'b0001, er);
        check("waddr", 256'(o_weight_addr), 256'(32'hA5));

        apb_write(A_IMG + 5, 32'hCAFE_0001, 4'hF, er);
        apb_write(A_IMGCMD, 32'h1, 4'hF, er);
        check("img_valid_set", 256'(o_img_valid), 256'(1));
        apb_write(A_IMG + 5, 32'h0, 4'hF, er);
        check("img_protect_err", 256'(er), 256'(1));
        check("img_protect_val", 256'(o_img_data[191:160]), 256'(32'hCAFE_0001));
        i_img_ready = 1;
        tick(1);
        i_img_ready = 0;
        check("img_handshake", 256'(o_img_valid), 256'(0));

        apb_write(A_RES, 32'h1, 4'hF, er);
        check("result_write_err", 256'(er), 256'(1));
        apb_read(A_IRQEN, 0, 0, rv, er);
`ifdef ACCEL_CSR_IRQ_EN
        check("irq_en_mapped", 256'(er), 256'(0));
        apb_write(A_IRQEN, 32'h1, 4'hF, er);
        i_result_valid = 1; i_result_data = RW'(32'h77);
        tick(1);
        i_result_valid = 0;
        tick(1);
        check("irq_asserted", 256'(o_irq), 256'(1));
        apb_write(A_IRQST, 32'h1, 4'hF, er);
        tick(1);
        check("irq_cleared", 256'(o_irq), 256'(0));
        apb_read(A_RES, 0, 0, rv, er);
        check("irq_result", 256'(rv), 256'(32'h77));
`else
        check("irq_en_unmapped", 256'(er), 256'(1));
        check("irq_tied_low", 256'(o_irq), 256'(0));
`endif

        apb_write(A_WCMD, 32'hF, 4'hF, er);
        apb_write(A_IMGCMD, 32'h1, 4'hF, er);
        check("pre_reset_cmd", 256'(o_cmd_valid), 256'(4'hF));
        PRESET = 1;
        tick(1);
        PRESET = 0;
        check("reset_cmd_drop", 256'(o_cmd_valid), 256'(0));
        check("reset_img_drop", 256'(o_img_valid), 256'(0));
        check("reset_weight", 256'(o_weight_data), 256'(0));
        tick(2);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
